uart_echo_channel: RTL and testbench

Parametrised self-contained UART echo channel with a 16x-oversampled receiver, an internal FIFO and a transmitter, all in one clock domain. Generalises the fixed 8-bit echo test with configurable baud divisor, data width and FIFO depth. Adds proper tx idle/pop handshaking, runtime modes (echo, uppercase, mute, hold), and overrun and framing-error counters. Sits at the board top level as the host-link bring-up and debug channel.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_echo_channel.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_uart_echo_channel.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and constants for the UART echo channel.
// Holds mode/state enums, oversampling timing and ASCII case-folding constants.
package uart_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO  = 2'b00,
        MODE_UPPER = 2'b01,
        MODE_MUTE  = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam int OVERSAMPLE   = 16;
    localparam int START_SAMPLE = 7;

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_OFFSET   = 8'h20;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the oldest entry.
// A push while full is dropped unless a pop in the same cycle frees a slot.
module uart_sync_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == FULL_LEVEL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_reg[rd_ptr_reg];
    assign level   = level_reg;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_channel.sv
// Host-link UART echo channel: 16x oversampled receiver -> FIFO -> transmitter,
// with echo/uppercase/mute/hold modes and saturating overrun/framing counters.
module uart_echo_channel
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 651,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_TICKS = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx,
    output logic                          tx,
    input  logic [1:0]                    mode,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overrun_count,
    output logic [15:0]                   frame_error_count,
    output logic                          busy
);
    localparam int DIV_W        = $clog2(CLK_DIV);
    localparam int DIV_LAST_I   = CLK_DIV - 1;
    localparam int OS_LAST_I    = OVERSAMPLE - 1;
    localparam int START_LAST_I = START_SAMPLE - 1;
    localparam int STOP_LAST_I  = STOP_TICKS - 1;
    localparam int BIT_LAST_I   = DATA_BITS - 1;

    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_LAST_I[DIV_W-1:0];
    localparam logic [3:0]       RX_OS_LAST    = OS_LAST_I[3:0];
    localparam logic [3:0]       RX_START_LAST = START_LAST_I[3:0];
    localparam logic [4:0]       TX_OS_LAST    = OS_LAST_I[4:0];
    localparam logic [4:0]       TX_STOP_LAST  = STOP_LAST_I[4:0];
    localparam logic [2:0]       BIT_LAST      = BIT_LAST_I[2:0];

    // Reset asserts immediately but releases only on a clock edge.
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    logic [DIV_W-1:0] div_reg;
    logic             tick;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign tick = (div_reg == DIV_LAST);

    logic rx_meta_reg;
    logic rx_sync_reg;
    logic rx_prev_reg;
    logic rx_fall;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    assign rx_fall = rx_prev_reg && !rx_sync_reg;

    rx_state_t  rx_state_reg, rx_state_next;
    logic [3:0] rx_tick_reg,  rx_tick_next;
    logic [2:0] rx_bit_reg,   rx_bit_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic       rx_done;
    logic       frame_err;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg <= RX_IDLE;
            rx_tick_reg  <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_tick_reg  <= rx_tick_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_tick_next  = rx_tick_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_done       = 1'b0;
        frame_err     = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_next = RX_START;
                    rx_tick_next  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_tick_reg == RX_START_LAST) begin
                        rx_tick_next  = '0;
                        rx_bit_next   = '0;
                        rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_next = rx_tick_reg + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_tick_reg == RX_OS_LAST) begin
                        rx_tick_next  = '0;
                        // LSB arrives first, so shift in from the top.
                        rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                        if (rx_bit_reg == BIT_LAST) begin
                            rx_state_next = RX_STOP;
                        end else begin
                            rx_bit_next = rx_bit_reg + 1'b1;
                        end
                    end else begin
                        rx_tick_next = rx_tick_reg + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_tick_reg == RX_OS_LAST) begin
                        rx_tick_next  = '0;
                        rx_state_next = RX_IDLE;
                        rx_done       = rx_sync_reg;
                        frame_err     = !rx_sync_reg;
                    end else begin
                        rx_tick_next = rx_tick_reg + 1'b1;
                    end
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    logic [DATA_BITS-1:0] rx_data;
    logic [DATA_BITS-1:0] push_data;

    assign rx_data = rx_shift_reg[7 -: DATA_BITS];

    generate
        if (DATA_BITS == 8) begin : g_upper
            always_comb begin
                push_data = rx_data;
                if (mode == MODE_UPPER && rx_data >= ASCII_LOWER_A && rx_data <= ASCII_LOWER_Z) begin
                    push_data = rx_data - CASE_OFFSET;
                end
            end
        end else begin : g_plain
            assign push_data = rx_data;
        end
    endgenerate

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 overrun;

    assign fifo_push = rx_done && (mode != MODE_MUTE);
    assign overrun   = fifo_push && fifo_full && !fifo_pop;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    logic [15:0] overrun_reg;
    logic [15:0] frame_err_reg;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            overrun_reg   <= '0;
            frame_err_reg <= '0;
        end else begin
            if (overrun && overrun_reg != 16'hFFFF) begin
                overrun_reg <= overrun_reg + 1'b1;
            end
            if (frame_err && frame_err_reg != 16'hFFFF) begin
                frame_err_reg <= frame_err_reg + 1'b1;
            end
        end
    end

    assign overrun_count     = overrun_reg;
    assign frame_error_count = frame_err_reg;

    tx_state_t            tx_state_reg, tx_state_next;
    logic [4:0]           tx_tick_reg,  tx_tick_next;
    logic [2:0]           tx_bit_reg,   tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_reg,       tx_next;
    logic                 can_pop;

    assign can_pop = !fifo_empty && (mode != MODE_HOLD);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg <= TX_IDLE;
            tx_tick_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_tick_reg  <= tx_tick_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_reg       <= tx_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_tick_next  = tx_tick_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_next       = tx_reg;
        fifo_pop      = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (can_pop) begin
                    fifo_pop      = 1'b1;
                    tx_shift_next = fifo_dout;
                    tx_tick_next  = '0;
                    tx_next       = 1'b0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_tick_reg == TX_OS_LAST) begin
                        tx_tick_next  = '0;
                        tx_bit_next   = '0;
                        tx_next       = tx_shift_reg[0];
                        tx_state_next = TX_DATA;
                    end else begin
                        tx_tick_next = tx_tick_reg + 1'b1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_tick_reg == TX_OS_LAST) begin
                        tx_tick_next  = '0;
                        tx_shift_next = tx_shift_reg >> 1;
                        if (tx_bit_reg == BIT_LAST) begin
                            tx_next       = 1'b1;
                            tx_state_next = TX_STOP;
                        end else begin
                            tx_bit_next = tx_bit_reg + 1'b1;
                            tx_next     = tx_shift_reg[1];
                        end
                    end else begin
                        tx_tick_next = tx_tick_reg + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_tick_reg == TX_STOP_LAST) begin
                        // Chain straight into the next frame when data is waiting.
                        if (can_pop) begin
                            fifo_pop      = 1'b1;
                            tx_shift_next = fifo_dout;
                            tx_tick_next  = '0;
                            tx_next       = 1'b0;
                            tx_state_next = TX_START;
                        end else begin
                            tx_tick_next  = '0;
                            tx_state_next = TX_IDLE;
                        end
                    end else begin
                        tx_tick_next = tx_tick_reg + 1'b1;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign tx   = tx_reg;
    assign busy = (rx_state_reg != RX_IDLE) || (tx_state_reg != TX_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_echo_channel.sv
// Directed bench for uart_echo_channel: drives serial frames on rx and decodes tx frames.
`timescale 1ns/1ps
module tb_uart_echo_channel;

    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int STOP_TICKS = 16;
    localparam int TX_BIT     = 16 * CLK_DIV;   // 64 cycles per tx bit
    localparam int RX_BIT     = 62;             // slightly fast so tx always has queued work

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic        tx;
    logic [1:0]  mode  = 2'b00;
    logic [4:0]  fifo_level;
    logic [15:0] overrun_count;
    logic [15:0] frame_error_count;
    logic        busy;

    uart_echo_channel #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .STOP_TICKS (STOP_TICKS)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .rx                (rx),
        .tx                (tx),
        .mode              (mode),
        .fifo_level        (fifo_level),
        .overrun_count     (overrun_count),
        .frame_error_count (frame_error_count),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned last_done_cyc = 0;
    int          fall_count = 0;
    logic [9:0]  frm_q[$];
    int unsigned fall_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] frame_of(input logic [7:0] d);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        return 32'(f);
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (dut.rx_done) last_done_cyc = cyc;
        end
    end

    // tx frame decoder: samples mid-bit after each detected falling edge.
    initial begin
        logic       prev_tx;
        logic       ok;
        logic [9:0] f;
        int unsigned fc;
        prev_tx = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (reset && prev_tx && !tx) begin
                ok = 1'b1;
                fc = cyc;
                fall_count++;
                repeat (TX_BIT / 2) begin
                    @(posedge clock); #1;
                    if (!reset) ok = 1'b0;
                end
                f[0] = tx;
                for (int b = 1; b < 10; b++) begin
                    repeat (TX_BIT) begin
                        @(posedge clock); #1;
                        if (!reset) ok = 1'b0;
                    end
                    f[b] = tx;
                end
                if (ok) begin
                    frm_q.push_back(f);
                    fall_q.push_back(fc);
                    $display("tx frame %0d: data=0x%02h start=%b stop=%b fall_cycle=%0d",
                             frm_q.size() - 1, f[8:1], f[0], f[9], fc);
                end
            end
            prev_tx = tx;
        end
    end

    task automatic rx_bit(input logic v);
        rx = v;
        repeat (RX_BIT) @(posedge clock);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
        rx_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (frm_q.size() < n && k < budget) begin
            @(posedge clock);
            k++;
        end
        #1;
        check_val($sformatf("%s frames arrived", tag), 32'(frm_q.size() >= n), 32'd1);
    endtask

    task automatic check_gap(input string tag, input int idx);
        int unsigned g;
        g = 0;
        if (idx >= 1 && idx < fall_q.size()) g = fall_q[idx] - fall_q[idx - 1];
        check_val($sformatf("%s gap %0d (spacing %0d)", tag, idx, g), 32'(g >= 636 && g <= 640), 32'd1);
    endtask

    initial begin
        #(3ms);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int fc0;
        int k;

        #3 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("reset tx", 32'(tx), 32'd1);
        check_val("reset fifo_level", 32'(fifo_level), 32'd0);
        check_val("reset overrun", 32'(overrun_count), 32'd0);
        check_val("reset frame_err", 32'(frame_error_count), 32'd0);
        check_val("reset busy", 32'(busy), 32'd0);
        @(posedge clock); #2;
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #2;

        // 1: plain echo of 0x55, latency and busy
        mode = 2'b00;
        base = frm_q.size();
        send_frame(8'h55, 1'b1);
        #1;
        check_val("t1 busy during frame", 32'(busy), 32'd1);
        wait_frames(base + 1, 1500, "t1");
        if (frm_q.size() > base) begin
            check_val("t1 frame 0x55", 32'(frm_q[base]), frame_of(8'h55));
            check_val("t1 rx_done to tx fall", fall_q[base] - last_done_cyc, 32'd2);
        end
        repeat (40) @(posedge clock);
        #1;
        check_val("t1 busy after stop", 32'(busy), 32'd0);
        check_val("t1 tx idle", 32'(tx), 32'd1);

        // 2: uppercase echo, back-to-back
        mode = 2'b01;
        base = frm_q.size();
        send_frame(8'h61, 1'b1);
        send_frame(8'h7B, 1'b1);
        send_frame(8'h5A, 1'b1);
        wait_frames(base + 3, 3000, "t2");
        if (frm_q.size() >= base + 3) begin
            check_val("t2 frame 0x61->0x41", 32'(frm_q[base]), frame_of(8'h41));
            check_val("t2 frame 0x7B", 32'(frm_q[base + 1]), frame_of(8'h7B));
            check_val("t2 frame 0x5A", 32'(frm_q[base + 2]), frame_of(8'h5A));
            check_gap("t2", base + 1);
            check_gap("t2", base + 2);
        end
        repeat (100) @(posedge clock);

        // 5: mute drops without counting overrun
        mode = 2'b10;
        base = frm_q.size();
        send_frame(8'h33, 1'b1);
        repeat (700) @(posedge clock);
        #1;
        check_val("t5 no tx frame", 32'(frm_q.size()), 32'(base));
        check_val("t5 fifo_level", 32'(fifo_level), 32'd0);
        check_val("t5 overrun", 32'(overrun_count), 32'd0);
        check_val("t5 busy", 32'(busy), 32'd0);

        // 3: hold fills FIFO, overruns, then drains back-to-back
        mode = 2'b11;
        base = frm_q.size();
        for (int i = 0; i < FIFO_DEPTH + 2; i++) send_frame(8'(i), 1'b1);
        repeat (100) @(posedge clock);
        #1;
        check_val("t3 fifo_level full", 32'(fifo_level), 32'd16);
        check_val("t3 overrun", 32'(overrun_count), 32'd2);
        check_val("t3 no tx while hold", 32'(frm_q.size()), 32'(base));
        check_val("t3 tx high while hold", 32'(tx), 32'd1);
        check_val("t3 busy while holding", 32'(busy), 32'd1);
        mode = 2'b00;
        wait_frames(base + FIFO_DEPTH, FIFO_DEPTH * 640 + 2000, "t3");
        if (frm_q.size() >= base + FIFO_DEPTH) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                check_val($sformatf("t3 drain byte %0d", i), 32'(frm_q[base + i]), frame_of(8'(i)));
                if (i > 0) check_gap("t3", base + i);
            end
        end
        repeat (60) @(posedge clock);
        #1;
        check_val("t3 fifo drained", 32'(fifo_level), 32'd0);
        check_val("t3 busy after drain", 32'(busy), 32'd0);
        check_val("t3 nothing extra", 32'(frm_q.size()), 32'(base + FIFO_DEPTH));

        // 4: framing error and start glitch, then a good frame
        mode = 2'b00;
        base = frm_q.size();
        send_frame(8'h5C, 1'b0);
        repeat (200) @(posedge clock);
        #2;
        rx = 1'b0;
        repeat (3 * CLK_DIV) @(posedge clock);
        #2;
        rx = 1'b1;
        repeat (200) @(posedge clock);
        #1;
        check_val("t4 frame_err count", 32'(frame_error_count), 32'd1);
        check_val("t4 no tx frame", 32'(frm_q.size()), 32'(base));
        check_val("t4 rx idle (busy)", 32'(busy), 32'd0);
        check_val("t4 tx idle", 32'(tx), 32'd1);
        send_frame(8'hA3, 1'b1);
        wait_frames(base + 1, 1500, "t4");
        if (frm_q.size() > base) check_val("t4 frame 0xA3", 32'(frm_q[base]), frame_of(8'hA3));
        repeat (100) @(posedge clock);

        // 6: asynchronous reset in the middle of a tx data bit
        base = frm_q.size();
        fc0 = fall_count;
        send_frame(8'hC9, 1'b1);
        k = 0;
        while (fall_count == fc0 && k < 2000) begin
            @(posedge clock);
            k++;
        end
        check_val("t6 tx started", 32'(fall_count != fc0), 32'd1);
        repeat (200) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_val("t6 tx forced high", 32'(tx), 32'd1);
        check_val("t6 fifo_level", 32'(fifo_level), 32'd0);
        check_val("t6 overrun cleared", 32'(overrun_count), 32'd0);
        check_val("t6 frame_err cleared", 32'(frame_error_count), 32'd0);
        check_val("t6 busy cleared", 32'(busy), 32'd0);
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        repeat (700) @(posedge clock);
        #2;
        base = frm_q.size();
        send_frame(8'h7E, 1'b1);
        wait_frames(base + 1, 1500, "t6");
        if (frm_q.size() > base) check_val("t6 frame 0x7E", 32'(frm_q[base]), frame_of(8'h7E));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
